// File: rtl/demux1x9_stream.sv
// Registered 1-to-9 valid/ready stream demultiplexer with a one-entry holding register per channel.
// Optional strict select checking is enabled by defining DEMUX1X9_STRICT_SEL_EN.
module demux1x9_stream #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [3:0]         in_sel,
    output logic [8:0]         out_valid,
    input  logic [8:0]         out_ready,
    output logic [9*WIDTH-1:0] out_data,
    output logic               drop_pulse,
    output logic [7:0]         drop_count
);

    localparam int NCH = 9;

    logic [NCH-1:0]   valid_q;
    logic [NCH-1:0]   valid_d;
    logic [WIDTH-1:0] data_q [NCH];
    logic [WIDTH-1:0] data_d [NCH];

    logic [3:0]       dest_s;
    logic [NCH-1:0]   dest_oh_s;
    logic             drop_s;
    logic             push_s;
    logic [NCH-1:0]   load_oh_s;

    // Decode the select exactly as the 9:1 mux tree reads it; strict mode flags 9..15 for discard.
    always_comb begin
        drop_s = 1'b0;
        if (in_sel[3] == 1'b0) begin
            dest_s = {1'b0, in_sel[2:0]};
        end else begin
            dest_s = 4'd8;
`ifdef DEMUX1X9_STRICT_SEL_EN
            if (in_sel[2:0] != 3'd0) begin
                drop_s = 1'b1;
            end else begin
                drop_s = 1'b0;
            end
`endif
        end
        dest_oh_s = 9'd1 << dest_s;
    end

    // Accept when the destination slot is empty or being drained this cycle; drops always accept.
    always_comb begin
        if (drop_s) begin
            in_ready = 1'b1;
        end else begin
            in_ready = |(dest_oh_s & (~valid_q | out_ready));
        end
        push_s    = in_valid & in_ready & ~drop_s;
        load_oh_s = push_s ? dest_oh_s : 9'd0;
    end

    // Next state per channel: a load wins over a pop so back-to-back beats keep valid high.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            valid_d[k] = load_oh_s[k] | (valid_q[k] & ~out_ready[k]);
            if (load_oh_s[k]) begin
                data_d[k] = in_data;
            end else begin
                data_d[k] = data_q[k];
            end
        end
    end

    // Channel holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 9'd0;
            for (int k = 0; k < NCH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < NCH; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Flatten channel payloads onto the output bus.
    always_comb begin
        out_valid = valid_q;
        for (int k = 0; k < NCH; k++) begin
            out_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

`ifdef DEMUX1X9_STRICT_SEL_EN
    logic       drop_pulse_q;
    logic       drop_pulse_d;
    logic [7:0] drop_count_q;
    logic [7:0] drop_count_d;

    // A discarded beat produces a one-cycle pulse and a saturating count.
    always_comb begin
        drop_pulse_d = in_valid & drop_s;
        if (drop_pulse_d && (drop_count_q != 8'd255)) begin
            drop_count_d = drop_count_q + 8'd1;
        end else begin
            drop_count_d = drop_count_q;
        end
    end

    // Drop reporting registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pulse_q <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;
`else
    assign drop_pulse = 1'b0;
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_demux1x9_stream.sv
// Directed self-checking bench for demux1x9_stream; follows DEMUX1X9_STRICT_SEL_EN when defined.
module tb_demux1x9_stream;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [3:0]         in_sel;
    logic [8:0]         out_valid;
    logic [8:0]         out_ready;
    logic [9*WIDTH-1:0] out_data;
    logic               drop_pulse;
    logic [7:0]         drop_count;

    int n_total;
    int n_bad;

    demux1x9_stream #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] slice(input logic [71:0] bus, input int k);
        return bus[k*8 +: 8];
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sel    = 4'd0;
        out_ready = 9'h000;
        #12;
        check_eq("rst_valid", {63'd0, out_valid}, 72'd0);
        check_eq("rst_data", out_data, 72'd0);
        check_eq("rst_drop_cnt", {64'd0, drop_count}, 72'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Idle: ready for every select.
        for (int s = 0; s < 16; s++) begin
            in_sel = s[3:0];
            #1;
            check_eq($sformatf("idle_ready_sel%0d", s), {71'd0, in_ready}, 72'd1);
        end

        // Single beat to channel 3.
        out_ready = 9'h1FF;
        in_valid  = 1'b1;
        in_sel    = 4'd3;
        in_data   = 8'hA5;
        #1;
        check_eq("ch3_ready", {71'd0, in_ready}, 72'd1);
        next_cycle();
        in_valid = 1'b0;
        check_eq("ch3_valid", {63'd0, out_valid}, 72'h008);
        check_eq("ch3_data", {64'd0, slice(out_data, 3)}, 72'hA5);
        next_cycle();
        check_eq("ch3_clear", {63'd0, out_valid}, 72'h000);
        check_eq("ch3_hold", {64'd0, slice(out_data, 3)}, 72'hA5);

        // Channel 5 stall, bypass to channel 2, then release and refill.
        out_ready = 9'h1DF;
        in_valid  = 1'b1;
        in_sel    = 4'd5;
        in_data   = 8'h11;
        #1;
        check_eq("ch5_first_ready", {71'd0, in_ready}, 72'd1);
        next_cycle();
        check_eq("ch5_first_valid", {63'd0, out_valid}, 72'h020);
        check_eq("ch5_first_data", {64'd0, slice(out_data, 5)}, 72'h11);
        in_data = 8'h22;
        #1;
        check_eq("ch5_stall_ready", {71'd0, in_ready}, 72'd0);
        next_cycle();
        check_eq("ch5_stall_data", {64'd0, slice(out_data, 5)}, 72'h11);
        in_sel  = 4'd2;
        in_data = 8'h33;
        #1;
        check_eq("ch2_bypass_ready", {71'd0, in_ready}, 72'd1);
        next_cycle();
        check_eq("ch2_bypass_valid", {63'd0, out_valid}, 72'h024);
        check_eq("ch2_bypass_data", {64'd0, slice(out_data, 2)}, 72'h33);
        in_sel    = 4'd5;
        in_data   = 8'h22;
        out_ready = 9'h1FF;
        #1;
        check_eq("ch5_release_ready", {71'd0, in_ready}, 72'd1);
        next_cycle();
        in_valid = 1'b0;
        check_eq("ch5_refill_valid", {63'd0, out_valid}, 72'h020);
        check_eq("ch5_refill_data", {64'd0, slice(out_data, 5)}, 72'h22);
        next_cycle();
        check_eq("ch5_drained", {63'd0, out_valid}, 72'h000);

        // Ten back-to-back beats to channel 8.
        in_valid = 1'b1;
        in_sel   = 4'd8;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'h40 + i[7:0];
            #1;
            check_eq($sformatf("ch8_ready_%0d", i), {71'd0, in_ready}, 72'd1);
            next_cycle();
            check_eq($sformatf("ch8_valid_%0d", i), {63'd0, out_valid}, 72'h100);
            check_eq($sformatf("ch8_data_%0d", i), {64'd0, slice(out_data, 8)}, 72'h40 + i);
        end
        in_valid = 1'b0;
        next_cycle();
        check_eq("ch8_drained", {63'd0, out_valid}, 72'h000);

        // Select 12: routed to channel 8, or dropped in strict mode.
        in_valid = 1'b1;
        in_sel   = 4'd12;
        in_data  = 8'h5C;
        #1;
        check_eq("sel12_ready", {71'd0, in_ready}, 72'd1);
        next_cycle();
        in_valid = 1'b0;
`ifdef DEMUX1X9_STRICT_SEL_EN
        check_eq("sel12_no_load", {63'd0, out_valid}, 72'h000);
        check_eq("sel12_ch8_kept", {64'd0, slice(out_data, 8)}, 72'h49);
        check_eq("sel12_pulse", {71'd0, drop_pulse}, 72'd1);
        check_eq("sel12_count", {64'd0, drop_count}, 72'd1);
        next_cycle();
        check_eq("sel12_pulse_end", {71'd0, drop_pulse}, 72'd0);
        check_eq("sel12_count_hold", {64'd0, drop_count}, 72'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_sel = 4'd9 + 4'(i % 7);
            next_cycle();
        end
        in_valid = 1'b0;
        next_cycle();
        check_eq("drop_saturate", {64'd0, drop_count}, 72'd255);
        check_eq("drop_no_load", {63'd0, out_valid}, 72'h000);
`else
        check_eq("sel12_ch8_valid", {63'd0, out_valid}, 72'h100);
        check_eq("sel12_ch8_data", {64'd0, slice(out_data, 8)}, 72'h5C);
        check_eq("sel12_no_pulse", {71'd0, drop_pulse}, 72'd0);
        next_cycle();
        check_eq("sel12_drained", {63'd0, out_valid}, 72'h000);
        check_eq("sel12_no_count", {64'd0, drop_count}, 72'd0);
`endif

        // Asynchronous reset while channels 0 and 7 hold data.
        out_ready = 9'h000;
        in_valid  = 1'b1;
        in_sel    = 4'd0;
        in_data   = 8'h0A;
        next_cycle();
        in_sel  = 4'd7;
        in_data = 8'h7E;
        next_cycle();
        in_valid = 1'b0;
        check_eq("pre_rst_valid", {63'd0, out_valid}, 72'h081);
        check_eq("pre_rst_ch7", {64'd0, slice(out_data, 7)}, 72'h7E);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", {63'd0, out_valid}, 72'h000);
        check_eq("async_rst_data", out_data, 72'd0);
        check_eq("async_rst_ready", {71'd0, in_ready}, 72'd1);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
